// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD stopwatch HH:MM:SS.cc with IDLE/RUN/PAUSE control.
// Define LAP_HOLD_EN to compile in the lap display-hold function.
module stopwatch_counter #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] hr_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] sec100_10s,
  output logic [3:0] sec100_1s,
  output logic       running,
  output logic       overflow
);
  localparam int NUM_DIG = 8;
  localparam int PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  // Per-digit terminal value, digit 0 = 1/100 s units ... digit 7 = tens of hours
  localparam logic [NUM_DIG*4-1:0] DIG_MAX =
    {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PW-1:0]            r_presc;
  logic [NUM_DIG-1:0][3:0]  r_live;
  logic [NUM_DIG-1:0][3:0]  r_disp;
  logic [NUM_DIG-1:0][3:0]  w_live_inc;
  logic [NUM_DIG-1:0][3:0]  w_disp_nxt;
  logic [NUM_DIG:0]         w_carry;
  logic                     w_tick;
  logic                     r_running;
  logic                     r_overflow;

  assign w_tick     = (r_state == S_RUN) && (r_presc == PRESC_MAX);
  assign w_carry[0] = w_tick;

  // Whole cascade resolves combinationally so every carry lands in the tick cycle
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    sw_bcd_digit #(.MAX(DIG_MAX[g*4 +: 4])) u_dig (
      .i_d    (r_live[g]),
      .i_cin  (w_carry[g]),
      .o_d    (w_live_inc[g]),
      .o_cout (w_carry[g+1])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_stop) begin
      case (r_state)
        S_IDLE, S_PAUSE: w_state_nxt = S_RUN;
        S_RUN:           w_state_nxt = S_PAUSE;
        default:         w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef LAP_HOLD_EN
  logic                    r_hold_on;
  logic                    w_hold_on_nxt;
  logic [NUM_DIG-1:0][3:0] r_hold;
  logic [NUM_DIG-1:0][3:0] w_hold_nxt;

  // Capture takes the pre-increment count even when a tick coincides
  assign w_hold_on_nxt = lap ? !r_hold_on : r_hold_on;
  assign w_hold_nxt    = (lap && !r_hold_on) ? r_live : r_hold;
  assign w_disp_nxt    = w_hold_on_nxt ? w_hold_nxt : w_live_inc;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_on <= 1'b0;
      r_hold    <= '0;
    end else if (clear) begin
      r_hold_on <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_hold_on <= w_hold_on_nxt;
      r_hold    <= w_hold_nxt;
    end
  end
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign w_disp_nxt   = w_live_inc;
`endif

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_live     <= '0;
      r_disp     <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_live     <= '0;
      r_disp     <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == S_RUN);
      if (r_state == S_RUN)
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_live <= w_live_inc;
      r_disp <= w_disp_nxt;
      if (w_carry[NUM_DIG])
        r_overflow <= 1'b1;
    end
  end

  assign sec100_1s  = r_disp[0];
  assign sec100_10s = r_disp[1];
  assign sec_1s     = r_disp[2];
  assign sec_10s    = r_disp[3];
  assign min_1s     = r_disp[4];
  assign min_10s    = r_disp[5];
  assign hr_1s      = r_disp[6];
  assign hr_10s     = r_disp[7];
  assign running    = r_running;
  assign overflow   = r_overflow;
endmodule

// One BCD digit of the cascade; wraps to 0 past MAX and raises carry-out.
module sw_bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic [3:0] i_d,
  input  logic       i_cin,
  output logic [3:0] o_d,
  output logic       o_cout
);
  assign o_cout = i_cin && (i_d >= MAX);
  assign o_d    = i_cin ? (o_cout ? 4'd0 : i_d + 4'd1) : i_d;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter (TICK_DIV=4): a centisecond-integer
// model pushes per-cycle expectations, a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_stopwatch_counter;
  localparam int DIV     = 4;
  localparam int WRAP_CS = 36_000_000;

  logic clk = 1'b0, rst_n = 1'b1, ss = 1'b0, clr = 1'b0, lp = 1'b0;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s;
  logic running, overflow;
  logic [31:0] w_disp;
  logic [31:0] pl;

  always #5 clk = ~clk;

  stopwatch_counter #(.TICK_DIV(DIV)) dut (
    .clk_100MHz(clk), .reset_n(rst_n), .start_stop(ss), .clear(clr), .lap(lp),
    .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s), .sec100_10s(sec100_10s), .sec100_1s(sec100_1s),
    .running(running), .overflow(overflow)
  );

  assign w_disp = {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s};

  typedef struct { int cs; bit run; bit ovf; } exp_t;
  exp_t  q[$];
  string qtag[$];
  string tag = "init";
  int    n_chk = 0, n_fail = 0;

  // Reference model: elapsed time as an integer number of centiseconds
  int m_cs = 0, m_phase = 0, m_hcs = 0;
  bit m_run = 0, m_ovf = 0, m_hold = 0;

  function automatic logic [31:0] to_bcd(int cs);
    int h, m, s, c;
    h = cs / 360000; m = (cs / 6000) % 60; s = (cs / 100) % 60; c = cs % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(string t, string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", t, name, act, exp);
    end
  endtask

  exp_t  mon_e;
  string mon_t;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_t = qtag.pop_front();
      chk(mon_t, "digits", w_disp, to_bcd(mon_e.cs));
      chk(mon_t, "running", {31'd0, running}, {31'd0, mon_e.run});
      chk(mon_t, "overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
    end
  end

  // Drive one cycle of pulses (called at a negedge), advance model, queue expectation
  task automatic step(bit s, bit c, bit l);
    bit tick;
    tick = 1'b0;
    ss = s; clr = c; lp = l;
    if (c) begin
      m_cs = 0; m_phase = 0; m_run = 0; m_ovf = 0; m_hold = 0; m_hcs = 0;
    end else begin
      if (m_run) begin
        m_phase = (m_phase + 1) % DIV;
        tick = (m_phase == 0);
      end
`ifdef LAP_HOLD_EN
      if (l) begin
        if (!m_hold) m_hcs = m_cs;
        m_hold = !m_hold;
      end
`endif
      if (tick) begin
        m_cs = m_cs + 1;
        if (m_cs == WRAP_CS) begin m_cs = 0; m_ovf = 1; end
      end
      if (s) m_run = !m_run;
    end
    q.push_back('{m_hold ? m_hcs : m_cs, m_run, m_ovf});
    qtag.push_back(tag);
    @(negedge clk);
    ss = 0; clr = 0; lp = 0;
  endtask

  task automatic run_until(int cs);
    int n;
    n = 0;
    while (m_cs != cs && n < 5000) begin step(0, 0, 0); n++; end
    if (m_cs != cs) begin
      n_chk++; n_fail++;
      $display("FAIL %s run_until: timed out at %0d, target %0d", tag, m_cs, cs);
    end
  endtask

  // Load the live count while paused; the register re-captures the forced value at the edge
  task automatic preload(int cs);
    pl = to_bcd(cs);
    force dut.r_live = pl;
    m_cs = cs;
    step(0, 0, 0);
    release dut.r_live;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    chk(tag, "reset digits", w_disp, 32'd0);
    chk(tag, "reset running", {31'd0, running}, 32'd0);
    chk(tag, "reset overflow", {31'd0, overflow}, 32'd0);
    m_cs = 0; m_phase = 0; m_run = 0; m_ovf = 0; m_hold = 0; m_hcs = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int h, mn, c;
    #2;
    tag = "reset"; do_reset();

    tag = "run40"; step(1, 0, 0); repeat (40) step(0, 0, 0);
    tag = "sec_carry"; run_until(99); run_until(100); repeat (2) step(0, 0, 0);

    tag = "hour_carry"; step(1, 0, 0); preload(359_999); step(1, 0, 0);
    run_until(360_000); repeat (2) step(0, 0, 0);

    // Pause with the prescaler at 2; resume must tick on the second run cycle
    tag = "pause_phase";
    begin
      int n;
      n = 0;
      while (m_phase != 1 && n < 10) begin step(0, 0, 0); n++; end
    end
    step(1, 0, 0); repeat (100) step(0, 0, 0); step(1, 0, 0); repeat (8) step(0, 0, 0);

    tag = "overflow"; step(1, 0, 0); preload(35_999_999); step(1, 0, 0);
    run_until(0); repeat (3) step(0, 0, 0);
    tag = "clear"; step(0, 1, 0); repeat (3) step(0, 0, 0);

    tag = "clr_vs_ss"; step(1, 0, 0); repeat (10) step(0, 0, 0); step(1, 1, 0);
    repeat (3) step(0, 0, 0);

    tag = "lap"; step(1, 0, 0); run_until(5); step(0, 0, 1);
    repeat (20) step(0, 0, 0); step(0, 0, 1); repeat (3) step(0, 0, 0);
    step(0, 1, 0);

    tag = "boundary";
    for (int i = 0; i < 6; i++) begin
      h  = int'($urandom_range(0, 99));
      mn = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
      c  = int'($urandom_range(95, 99));
      step(0, 1, 0); step(1, 0, 0); step(1, 0, 0);
      preload(((h * 60 + mn) * 60 + 59) * 100 + c);
      step(1, 0, 0); repeat (24) step(0, 0, 0);
    end

    tag = "random"; step(0, 1, 0); step(1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 5);

    tag = "midreset"; step(0, 1, 0); step(1, 0, 0); repeat (30) step(0, 0, 0);
    do_reset();
    tag = "after_reset"; repeat (3) step(0, 0, 0); step(1, 0, 0); repeat (12) step(0, 0, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1_000_000, meaning clk_100MHz cycles per 1/100 s tick (legal range 2 to 2^24).
REQ-002 SHALL have port clk_100MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_stop, input, 1 bit: single-cycle pulse (already debounced) that toggles run/pause.
REQ-005 SHALL have port clear, input, 1 bit: single-cycle pulse that zeroes the count.
REQ-006 SHALL have port lap, input, 1 bit: single-cycle pulse that toggles the display hold.
REQ-007 SHALL have ports hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s, output, 4 bits each: BCD display digits, registered.
REQ-008 SHALL have port running, output, 1 bit: high while in RUN.
REQ-009 SHALL have port overflow, output, 1 bit: sticky rollover flag.

Function
REQ-010 SHALL implement states IDLE (count zero, stopped), RUN and PAUSE.
REQ-011 State transitions on start_stop SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-012 clear SHALL force the state to IDLE from any state, zero all digits, the prescaler, overflow and the hold; it SHALL take priority over a same-cycle start_stop or lap, which are then ignored.
REQ-013 The prescaler SHALL count only in RUN, wrap at TICK_DIV-1, and assert an internal tick for one cycle at the wrap.
REQ-014 The prescaler SHALL hold its value in PAUSE, so a resumed run keeps sub-tick phase.
REQ-015 On each tick the live count SHALL increment by 0.01 s in BCD cascade: sec100 00-99, sec 00-59, min 00-59, hr 00-99; each carry SHALL be applied in the same cycle.
REQ-016 The live count SHALL be visible on the digit outputs one cycle after the tick cycle.
REQ-017 On a tick at 99:59:59.99 the count SHALL wrap to 00:00:00.00, overflow SHALL go to 1, and counting SHALL continue.
REQ-018 overflow SHALL stay at 1 until clear or reset.
REQ-019 No BCD digit SHALL ever take a value above 9; the tens digits of sec and min SHALL never exceed 5.
REQ-020 running SHALL equal (state == RUN), registered.

Reset
REQ-021 reset_n low SHALL asynchronously force: state IDLE, prescaler 0, all digit outputs 0, running 0, overflow 0, hold off, hold registers 0.
REQ-022 A reset asserted mid-count SHALL lose the count; there SHALL be no partial update on reset release.

Configuration
REQ-023 Macro LAP_HOLD_EN, when defined, SHALL compile in the lap hold function.
REQ-024 With LAP_HOLD_EN defined, a lap pulse with hold off SHALL copy the live count into hold registers and drive the outputs from those registers.
REQ-025 With LAP_HOLD_EN defined, a lap pulse with hold on SHALL release the hold, and the outputs SHALL show the live count on the next cycle.
REQ-026 With LAP_HOLD_EN defined, lap SHALL act in any state; a tick in the same cycle as a lap capture SHALL be captured as the pre-increment value.
REQ-027 With LAP_HOLD_EN defined, the live count SHALL keep running while hold is on.
REQ-028 Without LAP_HOLD_EN, lap SHALL be ignored, no hold registers SHALL exist, and the outputs SHALL always show the live count.

Verification (TICK_DIV=4)
REQ-029 Bench SHALL cover: reset, start_stop, 40 cycles -> digits 00:00:00.10, running=1.
REQ-030 Bench SHALL cover: run to 00:00:00.99, one more tick -> 00:00:01.00; preload toward 00:59:59.99, one tick -> 01:00:00.00.
REQ-031 Bench SHALL cover: start_stop at prescaler=2, wait 100 cycles, start_stop again -> digits unchanged during PAUSE; next tick 2 cycles after resume.
REQ-032 Bench SHALL cover: count at 99:59:59.99, one tick -> 00:00:00.00 with overflow=1; then clear -> overflow=0, state IDLE, running=0.
REQ-033 Bench SHALL cover: clear and start_stop in the same cycle while in RUN -> IDLE, digits 0, running=0.
REQ-034 Bench SHALL cover (LAP_HOLD_EN): lap at 00:00:00.05, run 20 cycles -> outputs stay 00:00:00.05; lap again -> outputs 00:00:00.10 next cycle.
